// File: rtl/level_meter_peak_hold.sv
// Per-channel log bar meter with fall-off and peak hold; one-cycle registered result.
// Backpressure: i_ready = !o_valid || o_ready; a stalled output holds every field stable.
module level_meter_peak_hold #(
    parameter int width          = 16,
    parameter int level_bits     = 5,
    parameter int hold_sections  = 8,
    parameter int decay_sections = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [width-1:0]      i_value,
    input  logic                  i_is_left,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic                  o_is_left,
    output logic [level_bits-1:0] o_bar,
    output logic [level_bits-1:0] o_peak
);

    localparam int HCW = ($clog2(hold_sections + 1) > 0) ? $clog2(hold_sections + 1) : 1;
    localparam int DCW = (decay_sections > 1) ? $clog2(decay_sections) : 1;
    localparam logic [HCW-1:0] HOLD_MAX  = HCW'(hold_sections);
    localparam logic [DCW-1:0] DEC_LAST  = DCW'(decay_sections - 1);

    // Index 1 = left channel, index 0 = right channel.
    logic [level_bits-1:0] bar_q  [2];
    logic [level_bits-1:0] peak_q [2];
    logic [HCW-1:0]        hold_q [2];
    logic [DCW-1:0]        dec_q  [2];

    logic                  o_valid_q, o_valid_d;
    logic                  o_is_left_q;
    logic [level_bits-1:0] o_bar_q, o_peak_q;

    logic                  accept;
    logic [level_bits-1:0] new_lvl;
    logic [level_bits-1:0] cur_bar, cur_peak, peak_m1;
    logic [HCW-1:0]        cur_hold;
    logic [DCW-1:0]        cur_dec;
    logic [level_bits-1:0] bar_d, peak_d;
    logic [HCW-1:0]        hold_d;
    logic [DCW-1:0]        dec_d;

    assign i_ready = !o_valid_q || o_ready;
    assign accept  = i_valid && i_ready;

    // Level is the position of the highest set bit plus one; zero input maps to level 0.
    always_comb begin
        new_lvl = '0;
        for (int i = 0; i < width; i++) begin
            if (i_value[i]) begin
                new_lvl = level_bits'(i + 1);
            end
        end
    end

    always_comb begin
        cur_bar  = bar_q[i_is_left];
        cur_peak = peak_q[i_is_left];
        cur_hold = hold_q[i_is_left];
        cur_dec  = dec_q[i_is_left];
        peak_m1  = cur_peak - 1'b1;
        bar_d    = cur_bar;
        dec_d    = cur_dec;
        peak_d   = cur_peak;
        hold_d   = cur_hold;

        if (new_lvl >= cur_bar) begin
            bar_d = new_lvl;
            dec_d = '0;
        end else if (cur_dec == DEC_LAST) begin
            bar_d = cur_bar - 1'b1;
            dec_d = '0;
        end else begin
            dec_d = cur_dec + 1'b1;
        end

        // A falling peak is clamped to the updated bar so the marker never sits below it.
        if (new_lvl >= cur_peak) begin
            peak_d = new_lvl;
            hold_d = '0;
        end else if (cur_hold < HOLD_MAX) begin
            hold_d = cur_hold + 1'b1;
        end else begin
            peak_d = (peak_m1 > bar_d) ? peak_m1 : bar_d;
            hold_d = HOLD_MAX;
        end
    end

    always_comb begin
        o_valid_d = o_valid_q;
        if (accept) begin
            o_valid_d = 1'b1;
        end else if (o_ready) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bar_q[0]    <= '0;
            bar_q[1]    <= '0;
            peak_q[0]   <= '0;
            peak_q[1]   <= '0;
            hold_q[0]   <= '0;
            hold_q[1]   <= '0;
            dec_q[0]    <= '0;
            dec_q[1]    <= '0;
            o_valid_q   <= 1'b0;
            o_is_left_q <= 1'b0;
            o_bar_q     <= '0;
            o_peak_q    <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            if (accept) begin
                bar_q[i_is_left]  <= bar_d;
                peak_q[i_is_left] <= peak_d;
                hold_q[i_is_left] <= hold_d;
                dec_q[i_is_left]  <= dec_d;
                o_is_left_q       <= i_is_left;
                o_bar_q           <= bar_d;
                o_peak_q          <= peak_d;
            end
        end
    end

    assign o_valid   = o_valid_q;
    assign o_is_left = o_is_left_q;
    assign o_bar     = o_bar_q;
    assign o_peak    = o_peak_q;

endmodule

// File: doc/level_meter_peak_hold.md
Name: level_meter_peak_hold

Overview:
- Downstream of the section-maximum stage. Consumes one per-section absolute maximum per channel, with left and right interleaved.
- Converts each maximum to a logarithmic bar level (MSB position).
- Applies a per-channel bar fall-off and a per-channel peak-hold marker.
- Emits bar/peak pairs to the display driver over a valid/ready handshake.

Parameters:
- width, 16, bit width of i_value (unsigned magnitude).
- level_bits, 5, width of level outputs; must hold 0..width.
- hold_sections, 8, updates a peak is held, per channel, before it starts falling.
- decay_sections, 2, updates per one-step bar fall, per channel; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  upstream sample valid.
- i_ready  out  1  block can accept a sample this cycle.
- i_value  in  width  section maximum magnitude.
- i_is_left  in  1  1 = left channel, 0 = right channel.
- o_valid  out  1  output pair valid.
- o_ready  in  1  downstream accepts the output.
- o_is_left  out  1  channel of the output pair.
- o_bar  out  level_bits  current bar level, 0..width.
- o_peak  out  level_bits  peak marker level; always ≥ o_bar.

Behaviour:
- One clock; reset is asynchronous and active-low. All registers clear immediately on assertion.
- Reset values: o_valid=0, o_is_left=0, o_bar=0, o_peak=0. Per-channel bar, peak, hold_cnt and decay_cnt are all 0.
- Handshake:
  - Accept when i_valid && i_ready; i_ready = !o_valid || o_ready.
  - Output transfer when o_valid && o_ready.
  - Accept and transfer in the same cycle is legal: the new result replaces the old one and o_valid stays 1.
  - o_valid && !o_ready holds all outputs stable.
- Latency: exactly one clock. The result is registered on the accepting edge.
- Level conversion (combinational):
  - new = 0 if i_value == 0.
  - Otherwise new = (index of highest set bit) + 1, range 1..width.
- Bar update, for channel c = i_is_left on accept:
  - new ≥ bar: bar = new, decay_cnt = 0.
  - Otherwise, decay_cnt == decay_sections-1: bar = bar-1, decay_cnt = 0.
  - Otherwise: decay_cnt += 1.
- Peak update, same accept, using bar_next (the value bar takes on this accept):
  - new ≥ peak: peak = new, hold_cnt = 0.
  - Otherwise, hold_cnt < hold_sections: hold_cnt += 1, peak unchanged.
  - Otherwise: peak = max(peak-1, bar_next); hold_cnt saturates at hold_sections.
- Outputs on accept: o_bar = bar_next, o_peak = peak_next, o_is_left = i_is_left.
- Channel isolation: an accept for one channel never modifies the other channel's state.
- Channel ordering: no L/R ordering is assumed. Consecutive same-channel samples are legal.
- Underflow: bar ≥ new always holds during decay, so bar-1 never goes below 0. Peak never falls below bar.
- A level of 0 with bar=0 leaves bar at 0. decay_cnt still counts.
- Reset mid-transfer discards the pending output; no handshake completes on that edge.
- Counters are sized $clog2(hold_sections+1) and $clog2(decay_sections).

Test Plan:
- Basic conversion: reset, then left 0x4444 → next cycle o_valid=1, o_is_left=1, o_bar=15, o_peak=15. Right 0x0000 → 0/0. Right 0x0001 → 1/1. Left 0xffff → 16/16.
- Decay (decay_sections=2): left 0x8000 then four left 0x0000 → o_bar 16, 16, 15, 15, 14.
- Hold (hold_sections=2, decay_sections=2): same sequence → o_peak 16, 16, 16, 15, 14. Peak never drops below bar.
- Channel independence: L 0xffff, R 0x0001, L 0x0000, R 0x3333 → L 16/16, R 1/1, L 16/16, R 14/14. No cross-channel effect.
- Backpressure: hold o_ready=0 after one result → i_ready=0, and outputs stay stable for 5 cycles despite i_valid=1. Raise o_ready with i_valid=1 → transfer and accept on the same edge, and the new result appears next cycle.
- Reset mid-operation: assert reset (low) while o_valid=1 and o_ready=0 → o_valid, o_bar, o_peak clear immediately. After release, left 0x0000 → bar 0, peak 0.
